addsub_arbiter: RTL
===================

// Module: addsub_arbiter
// PURPOSE
//   Shares one signed adder/subtractor datapath between two requesters.
//   Round-robin arbitration; valid/ready on each request port and on one
//   shared response port tagged with the requester id.
//   Sits between two client FSMs and a single addsub_core instance.
// PARAMETERS
//   WIDTH  4  operand/result width, two's complement signed
// PORTS
//   clk         in   1      single clock, rising edge
//   rst_n       in   1      reset, asynchronous, active-low
//   req0_valid  in   1      requester 0 has an operation
//   req0_ready  out  1      requester 0 operation accepted this cycle
//   req0_a      in   WIDTH  operand a (signed)
//   req0_b      in   WIDTH  operand b (signed)
//   req0_mode   in   1      0 = a+b, 1 = a-b
//   req1_*      --   --     identical set for requester 1
//   rsp_valid   out  1      result available
//   rsp_ready   in   1      consumer takes result
//   rsp_id      out  1      requester that issued the result
//   rsp_s       out  WIDTH  result (signed, wraps)
//   rsp_ovf     out  1      signed overflow flag
//   busy        out  1      state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE; last_grant=1 (req0 wins first); operand and result
//     regs = 0; rsp_valid=0; rsp_id=0; rsp_s=0; rsp_ovf=0; req*_ready=0.
//   FSM IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: grant = only valid requester; if both valid, the one != last_grant.
//     reqN_ready = (state==IDLE) & grantN (combinational, one-hot, never both).
//     On handshake: capture a, b, mode, id; last_grant <= id; go EXEC.
//     No valid: stay IDLE.
//   EXEC: addsub_core on registered operands; capture s, ovf into result
//     regs; go RESP.
//   RESP: rsp_valid=1; rsp_id/s/ovf stable until rsp_ready; on
//     rsp_valid&rsp_ready go IDLE.
//   Latency: handshake in cycle N -> rsp_valid high in cycle N+2.
//     Min issue interval 3 cycles. No request accepted outside IDLE.
//   Arithmetic: s = a + (b ^ {WIDTH{mode}}) + mode, modulo 2^WIDTH.
//     ovf = carry into MSB XOR carry out of MSB.
//   Requester may drop valid before ready without penalty; no request is
//     lost while valid stays high (fairness: at most one other op ahead).
//   Response back-pressure: RESP holds indefinitely; both requesters stall.
//   Reset mid-operation: in-flight op discarded, no response emitted,
//     all state back to reset values.
// STRUCTURE
//   Package addsub_pkg: WIDTH default, state enum {IDLE, EXEC, RESP},
//     MODE_ADD=0 / MODE_SUB=1 constants.
//   Sub-module: addsub_core (WIDTH-parameterised ripple adder/subtractor,
//     outputs s and ovf), purely combinational, one instance.
// TESTING
//   Reset release, req0: 7+1 (mode 0) -> 2 cycles later rsp_id=0, s=-8, ovf=1.
//   req1 only: -8-1 (mode 1) -> rsp_id=1, s=7, ovf=1; 3-5 -> s=-2, ovf=0.
//   Both valid every cycle, rsp_ready=1: grants alternate 0,1,0,1; each
//     result carries correct id; -8-(-8) -> s=0, ovf=0.
//   rsp_ready=0 for 5 cycles in RESP: rsp_* stable, req*_ready=0 throughout.
//   rst_n low during EXEC: outputs to reset values same cycle, no rsp_valid
//     afterwards; next op granted to req0 if both valid.
//   Random operands/modes both ports vs reference model: s and ovf match
//     over 10k ops, no starvation (max wait 1 op).

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared constants and types for the two-requester add/sub arbiter.
package addsub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_core.sv
// Combinational ripple-carry adder/subtractor with signed overflow flag.
module addsub_core #(
    parameter int WIDTH = addsub_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic [WIDTH-1:0] s,
    output logic             ovf
);
    import addsub_pkg::*;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   carry;

    // Subtraction is a + ~b + 1: invert b and feed the +1 in as carry-in.
    always_comb begin
        b_eff    = b ^ {WIDTH{mode == MODE_SUB}};
        carry    = '0;
        carry[0] = (mode == MODE_SUB);
        s        = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]       = a[i] ^ b_eff[i] ^ carry[i];
            carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
        end
        ovf = carry[WIDTH] ^ carry[WIDTH-1];
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one addsub_core between two valid/ready
// requesters; results leave on a single tagged valid/ready response port.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_mode,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_ovf,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mode_q, mode_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             ovf_q, ovf_d;

    logic             grant0;
    logic             grant1;
    logic [WIDTH-1:0] core_s;
    logic             core_ovf;

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a    (a_q),
        .b    (b_q),
        .mode (mode_q),
        .s    (core_s),
        .ovf  (core_ovf)
    );

    // Gating with rst_n keeps both ready lines low while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE && rst_n) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        mode_d       = mode_q;
        id_d         = id_q;
        s_d          = s_q;
        ovf_d        = ovf_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    a_d          = grant1 ? req1_a    : req0_a;
                    b_d          = grant1 ? req1_b    : req0_b;
                    mode_d       = grant1 ? req1_mode : req0_mode;
                    id_d         = grant1;
                    last_grant_d = grant1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                s_d     = core_s;
                ovf_d   = core_ovf;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            mode_q       <= MODE_ADD;
            id_q         <= 1'b0;
            s_q          <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mode_q       <= mode_d;
            id_q         <= id_d;
            s_q          <= s_d;
            ovf_q        <= ovf_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_s      = s_q;
    assign rsp_ovf    = ovf_q;
    assign busy       = (state_q != IDLE);

endmodule
